jtag_mem_access: RTL

JTAG_MEM_ACCESS -- requirements
Module: jtag_mem_access

---
 rtl/jtag_mem_pkg.sv | 22 ++
 rtl/jtag_mem_access.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/jtag_mem_pkg.sv
// Shared types and constants for the JTAG memory-access data chain.
// Status bits sit directly above the read buffer in the captured word.
package jtag_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } state_t;

  function automatic int err_pos(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int busy_pos(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/jtag_mem_access.sv
// JTAG user data chain that turns UPDATE strobes into single memory-bus
// reads or writes, with optional address auto-increment and sticky overrun flag.
module jtag_mem_access
  import jtag_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              TCK,
  input  logic              RESET_N,
  input  logic              SEL,
  input  logic              CAPTURE,
  input  logic              SHIFT,
  input  logic              UPDATE,
  input  logic              TDI,
  output logic              TDO,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              ADDR_LD,
  input  logic              INC,
  input  logic              WR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_GNT,
  input  logic              MEM_RVALID,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output state_t            dbg_state
);

  localparam int SR_W  = DATA_W + 2;
  localparam int ERR_B = err_pos(DATA_W);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

  // Bus handshake: MEM_REQ is held with stable address/data until MEM_GNT is
  // sampled high on a TCK edge; read data is taken on the edge MEM_RVALID is high.

  state_t state_q, state_d;

  logic [SR_W-1:0]   sr_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdbuf_q;
  logic              we_q;
  logic              err_q;

  logic upd;
  logic busy;
  logic launch;
  logic complete;
  logic set_err;
  logic clr_err;

  assign upd       = SEL & UPDATE;
  assign busy      = (state_q != ST_IDLE);
  assign TDO       = sr_q[0];
  assign dbg_state = state_q;

  always_ff @(posedge TCK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    complete  = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    MEM_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    case (state_q)
      ST_IDLE: begin
        if (upd) begin
          // A set top bit makes this UPDATE a flag-clear command only.
          if (sr_q[ERR_B]) begin
            clr_err = 1'b1;
          end else begin
            launch  = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        MEM_REQ   = 1'b1;
        MEM_WE    = we_q;
        MEM_ADDR  = cur_addr_q;
        MEM_WDATA = wdata_q;
        if (MEM_GNT) begin
          if (we_q) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_WAIT_R;
          end
        end
        set_err = upd | (ADDR_LD & ~complete);
      end
      ST_WAIT_R: begin
        if (MEM_RVALID) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
        set_err = upd | (ADDR_LD & ~complete);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge TCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sr_q <= '0;
    end else if (SEL && CAPTURE) begin
      sr_q <= {err_q, busy, rdbuf_q};
    end else if (SEL && SHIFT) begin
      sr_q <= {TDI, sr_q[SR_W-1:1]};
    end
  end

  always_ff @(posedge TCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (launch) begin
      wdata_q <= sr_q[DATA_W-1:0];
      we_q    <= WR;
    end
  end

  // An address load at completion wins over the auto-increment.
  always_ff @(posedge TCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_addr_q <= '0;
    end else if (ADDR_LD && (!busy || complete)) begin
      cur_addr_q <= ADDR;
    end else if (complete && INC) begin
      cur_addr_q <= cur_addr_q + ADDR_STEP;
    end
  end

  always_ff @(posedge TCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rdbuf_q <= '0;
    end else if (state_q == ST_WAIT_R && MEM_RVALID) begin
      rdbuf_q <= MEM_RDATA;
    end
  end

  always_ff @(posedge TCK or negedge RESET_N) begin
    if (!RESET_N)     err_q <= 1'b0;
    else if (set_err) err_q <= 1'b1;
    else if (clr_err) err_q <= 1'b0;
  end

endmodule
